cond_test_unit: RTL

Parametrised, pipelined condition evaluator for the EX stage of the 5-stage pipeline. It resolves branch and flag conditions on a WIDTH-bit operand under a selectable mode with optional inversion. Output carries valid/ready flow control, flush and saturating statistics counters. The legacy single-bit "out = !tst" behaviour is the case WIDTH=1, mode EQZ, invert=0.

---
 rtl/cond_test_pkg.sv | 50 +++++
 rtl/cond_test_unit_sat_counter.sv | 25 ++
 rtl/cond_test_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/cond_test_pkg.sv
// Shared definitions for the condition test unit: mode codes, evaluator, stage entry.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package cond_test_pkg;

  // Condition select codes
  localparam logic [2:0] MODE_EQZ    = 3'd0;
  localparam logic [2:0] MODE_NEZ    = 3'd1;
  localparam logic [2:0] MODE_LTZ    = 3'd2;
  localparam logic [2:0] MODE_GEZ    = 3'd3;
  localparam logic [2:0] MODE_GTZ    = 3'd4;
  localparam logic [2:0] MODE_LEZ    = 3'd5;
  localparam logic [2:0] MODE_ALWAYS = 3'd6;
  localparam logic [2:0] MODE_NEVER  = 3'd7;

  // Operands are sign-extended to MAX_WIDTH before evaluation; WIDTH must not exceed it.
  localparam int MAX_WIDTH = 64;
  // Tags are zero-extended to MAX_TAG_W inside the pipe; TAG_W must not exceed it.
  localparam int MAX_TAG_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 taken;
    logic [MAX_TAG_W-1:0] tag;
  } stage_t;

  // Signed compare against zero; data is already sign-extended so the MSB is the sign.
  function automatic logic cond_eval(input logic [MAX_WIDTH-1:0] data,
                                     input logic [2:0]           mode,
                                     input logic                 invert);
    logic zero;
    logic neg;
    logic c;
    zero = (data == '0);
    neg  = data[MAX_WIDTH-1];
    case (mode)
      MODE_EQZ:    c = zero;
      MODE_NEZ:    c = !zero;
      MODE_LTZ:    c = neg;
      MODE_GEZ:    c = !neg;
      MODE_GTZ:    c = !neg && !zero;
      MODE_LEZ:    c = neg || zero;
      MODE_ALWAYS: c = 1'b1;
      MODE_NEVER:  c = 1'b0;
      default:     c = 1'b0;
    endcase
    return c ^ invert;
  endfunction

endpackage

// File: rtl/cond_test_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count reflects inc/clr one cycle after the edge that samples them.
// Backpressure: none; inc is ignored once the counter is at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear has priority; increment stops at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cond_test_unit.sv
// Pipelined branch/flag condition evaluator with valid/ready output and statistics.
// Latency: STAGES cycles from the accepting edge to out_valid; one result per cycle.
// Backpressure: global stall when out_valid && !out_ready; flush kills all in-flight entries.
module cond_test_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  input  logic             in_invert,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  import cond_test_pkg::*;

  stage_t [STAGES-1:0]  pipe;
  logic                 advance;
  logic                 handshake;
  logic                 eval_res;
  logic [MAX_WIDTH-1:0] data_ext;
  logic [MAX_TAG_W-1:0] tag_ext;
  logic                 unused_tag_hi;

  // Widen operand (sign) and tag (zero) to the package-wide widths.
  always_comb begin
    data_ext              = {MAX_WIDTH{in_data[WIDTH-1]}};
    data_ext[WIDTH-1:0]   = in_data;
    tag_ext               = '0;
    tag_ext[TAG_W-1:0]    = in_tag;
  end

  // Only the 1-bit outcome travels down the pipe, never the operand.
  assign eval_res = cond_eval(data_ext, in_mode, in_invert);

  assign advance   = !pipe[STAGES-1].valid || out_ready;
  assign in_ready  = advance && !flush;
  assign out_valid = pipe[STAGES-1].valid;
  assign out_taken = pipe[STAGES-1].taken;
  assign out_tag   = pipe[STAGES-1].tag[TAG_W-1:0];

  // Tag bits above TAG_W are always zero; they are gathered here so the narrowing is explicit.
  assign unused_tag_hi = ^pipe[STAGES-1].tag;

  // Shift chain: flush clears every valid bit, otherwise shift on advance, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe[i].valid <= 1'b0;
      end
    end else if (advance) begin
      pipe[0] <= '{valid: in_valid && in_ready, taken: eval_res, tag: tag_ext};
      for (int i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // A flushed output handshake does not count as a delivered result.
  assign handshake = pipe[STAGES-1].valid && out_ready && !flush;

  sat_counter #(.W(CNT_W)) u_eval_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake),
    .clr   (cnt_clr),
    .count (eval_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake && pipe[STAGES-1].taken),
    .clr   (cnt_clr),
    .count (taken_cnt)
  );

endmodule
